// File: rtl/bus_arbiter16_pkg.sv
// bus_arbiter16_pkg: shared sizes, output-stage state encoding and a one-hot helper
// for the four-way round-robin arbiter. The optional burst lock is enabled by ARB_LOCK_EN.
package bus_arbiter16_pkg;

  localparam int WIDTH = 16;  // data word width
  localparam int NREQ  = 4;   // requester count (fixed)
  localparam int IDX_W = 2;   // source index width

  // Output stage occupancy; out_valid is simply (state == FULL)
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // One-hot request/ack vector for a source index
  function automatic logic [NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_arbiter16_if.sv
// bus_arbiter16_if: requester side (req/lock/data/ack) and consumer side
// (out_valid/out_ready/out_data/out_src) of the arbiter plus the transfer counter.
// master = the arbiter, slave = the environment driving requests and consuming words.
interface bus_arbiter16_if;
  import bus_arbiter16_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  lock;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic [NREQ-1:0]  ack;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [IDX_W-1:0] out_src;
  logic [WIDTH-1:0] xfer_cnt;

  modport master (
    input  req, lock, data0, data1, data2, data3, out_ready,
    output ack, out_valid, out_data, out_src, xfer_cnt
  );

  modport slave (
    output req, lock, data0, data1, data2, data3, out_ready,
    input  ack, out_valid, out_data, out_src, xfer_cnt
  );

endinterface

// File: rtl/bus_arbiter16_mux4way16.sv
// mux4way16: combinational 4:1 word select built as a two-level tree of
// mux2way16 cells. Low index bit picks within a pair, high bit picks the pair.
module mux2way16
  import bus_arbiter16_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? b : a;
endmodule

module mux4way16
  import bus_arbiter16_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [IDX_W-1:0] sel,
  output logic [WIDTH-1:0] y
);
  logic [WIDTH-1:0] ins [NREQ];
  logic [WIDTH-1:0] lvl [2];

  assign ins[0] = a;
  assign ins[1] = b;
  assign ins[2] = c;
  assign ins[3] = d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_pair
    mux2way16 u_pair (
      .a   (ins[2*gi]),
      .b   (ins[2*gi+1]),
      .sel (sel[0]),
      .y   (lvl[gi])
    );
  end

  mux2way16 u_top (
    .a   (lvl[0]),
    .b   (lvl[1]),
    .sel (sel[1]),
    .y   (y)
  );
endmodule

// File: rtl/bus_arbiter16.sv
// bus_arbiter16: round-robin arbiter feeding one registered 16-bit output stage
// with a valid/ready handshake. ack is combinational; everything else is registered.
// Optional burst lock (lock owner keeps priority) is built only with ARB_LOCK_EN.
module bus_arbiter16
  import bus_arbiter16_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  bus_arbiter16_if.master bus
);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg;
  logic [WIDTH-1:0] data_reg;
  logic [IDX_W-1:0] src_reg;
  logic [WIDTH-1:0] cnt_reg;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] winner;
  logic [WIDTH-1:0] mux_word;
  logic             free;
  logic             cap;
  logic             hs;
  logic             hold_ptr;

`ifdef ARB_LOCK_EN
  logic             lock_act_reg;
  logic [IDX_W-1:0] lock_own_reg;

  // While a lock is held only the owner may be captured
  always_comb begin
    elig = bus.req;
    if (lock_act_reg) elig = bus.req & idx_onehot(lock_own_reg);
  end

  // A locked capture keeps the pointer so the owner stays first in line
  assign hold_ptr = bus.lock[winner];

  // Lock owner: set/cleared by each capture, dropped if the owner stops requesting while free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_act_reg <= 1'b0;
      lock_own_reg <= '0;
    end else if (cap) begin
      lock_act_reg <= bus.lock[winner];
      lock_own_reg <= winner;
    end else if (lock_act_reg && free && !bus.req[lock_own_reg]) begin
      lock_act_reg <= 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign elig        = bus.req;
  assign hold_ptr    = 1'b0;
`endif

  // Rotate the eligible vector so bit 0 is the source the pointer favours
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    assign rot[gi] = elig[ptr_reg + IDX_W'(gi)];
  end

  // First set bit of the rotated vector is the offset of the winner from ptr
  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
  end

  assign winner = ptr_reg + off;
  assign free   = (state_reg == EMPTY) || bus.out_ready;
  assign hs     = (state_reg == FULL) && bus.out_ready;
  // Reset gates the capture so ack stays low while rst_n is asserted
  assign cap    = rst_n && free && (|elig);

  assign bus.ack       = cap ? idx_onehot(winner) : '0;
  assign bus.out_valid = (state_reg == FULL);
  assign bus.out_data  = data_reg;
  assign bus.out_src   = src_reg;
  assign bus.xfer_cnt  = cnt_reg;

  mux4way16 u_mux (
    .a   (bus.data0),
    .b   (bus.data1),
    .c   (bus.data2),
    .d   (bus.data3),
    .sel (winner),
    .y   (mux_word)
  );

  // Next state: a capture fills the stage, a bare handshake empties it
  always_comb begin
    state_next = state_reg;
    if (cap)     state_next = FULL;
    else if (hs) state_next = EMPTY;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // Captured word, source, round-robin pointer and handshake counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg <= '0;
      src_reg  <= '0;
      ptr_reg  <= '0;
      cnt_reg  <= '0;
    end else begin
      if (cap) begin
        data_reg <= mux_word;
        src_reg  <= winner;
        if (!hold_ptr) ptr_reg <= winner + IDX_W'(1);
      end
      if (hs) cnt_reg <= cnt_reg + WIDTH'(1);
    end
  end

endmodule
